// File: rtl/ps2_keyboard.sv
// ps2_keyboard: PS/2 host-side receiver and scan-code decoder.
//   Synchronizes and filters the keyboard clock, deframes 11-bit frames
//   (start, 8 data bits LSB first, odd parity, stop) and strips the E0/F0
//   prefixes. Each completed key event is reported as a base scan code,
//   a make/break flag and a one-cycle valid pulse.
// Optional feature: define PS2_PARITY_CHECK_EN to reject frames that fail
//   the odd-parity check; otherwise the parity bit is sampled and ignored.
// Ports:
//   clk                 system clock
//   rst                 synchronous active-high reset
//   ps2_clk, ps2_data   asynchronous PS/2 lines, idle high
//   current_scan_code   base scan code of the last event
//   current_make_break  1 = make, 0 = break for the last event
//   key_event_valid     one-clock pulse when a new event is loaded
module ps2_keyboard #(
  parameter int unsigned FILTER_LEN     = 8,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] current_scan_code,
  output logic       current_make_break,
  output logic       key_event_valid
);

  localparam int unsigned FiltW = $clog2(FILTER_LEN + 1);
  localparam int unsigned TmoW  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int unsigned CntW  = 4;
  localparam logic [7:0]  CodeExt = 8'hE0;
  localparam logic [7:0]  CodeBrk = 8'hF0;

`ifdef PS2_PARITY_CHECK_EN
  localparam bit ParityEn = 1'b1;
`else
  localparam bit ParityEn = 1'b0;
`endif

  // Synchronizers, filter, deframer and decoder state
  logic [1:0]      clk_sync_q, data_sync_q;
  logic            filt_q, filt_d;
  logic [FiltW-1:0] fcnt_q, fcnt_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_q, par_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            byte_vld_q, byte_vld_d;
  logic [7:0]      byte_q, byte_d;
  logic            ext_q, ext_d;
  logic            brk_q, brk_d;
  logic [7:0]      code_d;
  logic            mb_d;
  logic            vld_d;

  logic clk_s_c, data_s_c, strobe_c, par_ok_c;

  assign clk_s_c  = clk_sync_q[1];
  assign data_s_c = data_sync_q[1];
  // Odd parity over data plus parity bit
  assign par_ok_c = ^{shift_q, par_q};

  // Stability filter: the filtered clock follows the synchronized clock only
  // after it has held a new level for FILTER_LEN consecutive cycles.
  always_comb begin
    filt_d = filt_q;
    fcnt_d = '0;
    if (clk_s_c != filt_q) begin
      if (fcnt_q == FiltW'(FILTER_LEN - 1)) begin
        filt_d = clk_s_c;
      end else begin
        fcnt_d = fcnt_q + FiltW'(1);
      end
    end
  end

  // A filtered falling edge is the bit sample strobe
  assign strobe_c = filt_q & ~filt_d;

  // Deframer with partial-frame timeout
  always_comb begin
    cnt_d      = cnt_q;
    shift_d    = shift_q;
    par_d      = par_q;
    tmo_d      = '0;
    byte_vld_d = 1'b0;
    byte_d     = byte_q;
    if (strobe_c) begin
      if (cnt_q == CntW'(0)) begin
        // A high start bit is noise; stay waiting for a real start
        if (!data_s_c) begin
          cnt_d = CntW'(1);
        end
      end else if (cnt_q <= CntW'(8)) begin
        shift_d = {data_s_c, shift_q[7:1]};
        cnt_d   = cnt_q + CntW'(1);
      end else if (cnt_q == CntW'(9)) begin
        par_d = data_s_c;
        cnt_d = CntW'(10);
      end else begin
        cnt_d = '0;
        if (data_s_c && (par_ok_c || !ParityEn)) begin
          byte_vld_d = 1'b1;
          byte_d     = shift_q;
        end
      end
    end else if (cnt_q != CntW'(0)) begin
      if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
        cnt_d = '0;
      end else begin
        tmo_d = tmo_q + TmoW'(1);
      end
    end
  end

  // Prefix stripping and event generation, one cycle after frame completion
  always_comb begin
    ext_d  = ext_q;
    brk_d  = brk_q;
    code_d = current_scan_code;
    mb_d   = current_make_break;
    vld_d  = 1'b0;
    if (byte_vld_q) begin
      if (byte_q == CodeExt) begin
        ext_d = 1'b1;
      end else if (byte_q == CodeBrk) begin
        brk_d = 1'b1;
      end else begin
        code_d = byte_q;
        mb_d   = ~brk_q;
        vld_d  = 1'b1;
        ext_d  = 1'b0;
        brk_d  = 1'b0;
      end
    end
  end

  // State registers
  always_ff @(posedge clk) begin
    if (rst) begin
      clk_sync_q         <= 2'b11;
      data_sync_q        <= 2'b11;
      filt_q             <= 1'b1;
      fcnt_q             <= '0;
      cnt_q              <= '0;
      shift_q            <= '0;
      par_q              <= 1'b0;
      tmo_q              <= '0;
      byte_vld_q         <= 1'b0;
      byte_q             <= '0;
      ext_q              <= 1'b0;
      brk_q              <= 1'b0;
      current_scan_code  <= '0;
      current_make_break <= 1'b0;
      key_event_valid    <= 1'b0;
    end else begin
      clk_sync_q         <= {clk_sync_q[0], ps2_clk};
      data_sync_q        <= {data_sync_q[0], ps2_data};
      filt_q             <= filt_d;
      fcnt_q             <= fcnt_d;
      cnt_q              <= cnt_d;
      shift_q            <= shift_d;
      par_q              <= par_d;
      tmo_q              <= tmo_d;
      byte_vld_q         <= byte_vld_d;
      byte_q             <= byte_d;
      ext_q              <= ext_d;
      brk_q              <= brk_d;
      current_scan_code  <= code_d;
      current_make_break <= mb_d;
      key_event_valid    <= vld_d;
    end
  end

endmodule

// File: tb/tb_ps2_keyboard.sv
// tb_ps2_keyboard: randomized and directed checks of ps2_keyboard against a
// byte-level model of the PS/2 key-event rules. PS/2 timing is scaled down
// (short bit period, short timeout) to keep the run brief.
module tb_ps2_keyboard;

  localparam int unsigned FILT = 8;
  localparam int unsigned TMO  = 3000;
  localparam int HALF = 25;   // clk cycles per PS/2 clock phase
  localparam int GAP  = 150;  // clk cycles between bytes

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [7:0] current_scan_code;
  logic       current_make_break;
  logic       key_event_valid;

  int checks = 0;
  int errors = 0;
  int consec = 0;
  logic prev_vld = 1'b0;

  // Observed and expected events, each {code, make}
  logic [8:0] obs_q[$];
  logic [8:0] exp_q[$];

  // Model state
  bit         m_ext = 0;
  bit         m_brk = 0;
  logic [7:0] last_code = 8'h00;
  logic       last_mb = 1'b0;

  ps2_keyboard #(.FILTER_LEN(FILT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk               (clk),
    .rst               (rst),
    .ps2_clk           (ps2_clk),
    .ps2_data          (ps2_data),
    .current_scan_code (current_scan_code),
    .current_make_break(current_make_break),
    .key_event_valid   (key_event_valid)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (key_event_valid) begin
      obs_q.push_back({current_scan_code, current_make_break});
      if (prev_vld) consec++;
    end
    prev_vld <= key_event_valid;
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Model: what one accepted byte means at the key-event level
  task automatic model_feed(input logic [7:0] b);
    if (b == 8'hE0) m_ext = 1;
    else if (b == 8'hF0) m_brk = 1;
    else begin
      exp_q.push_back({b, ~m_brk});
      last_code = b;
      last_mb = ~m_brk;
      m_ext = 0;
      m_brk = 0;
    end
  endtask

  // Drive the first nbits of a frame; data changes half a period before each fall
  task automatic send_frame(input logic [7:0] b, input bit bad_par, input int nbits);
    logic [10:0] f;
    f = {1'b1, (~(^b)) ^ bad_par, b, 1'b0};
    for (int i = 0; i < nbits; i++) begin
      ps2_data = f[i];
      wait_clks(HALF);
      ps2_clk = 1'b0;
      wait_clks(HALF);
      ps2_clk = 1'b1;
    end
    ps2_data = 1'b1;
    wait_clks(GAP);
  endtask

  task automatic send_byte(input logic [7:0] b);
    send_frame(b, 1'b0, 11);
    model_feed(b);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    wait_clks(4);
    @(negedge clk);
    checks++;
    if ({current_scan_code, current_make_break, key_event_valid} !== 10'h000) begin
      errors++;
      $display("FAIL reset_outputs: got code=%h mb=%b vld=%b, required 00/0/0",
               current_scan_code, current_make_break, key_event_valid);
    end
    rst = 1'b0;
    wait_clks(20);
  endtask

  task automatic test_directed();
    logic [7:0] seq[11] = '{8'h1C, 8'hF0, 8'h1C, 8'hE0, 8'h6B, 8'hE0, 8'hF0, 8'h6B,
                            8'h12, 8'h29, 8'hE0};
    for (int i = 0; i < 11; i++) send_byte(seq[i]);
    send_byte(8'h75);
    wait_clks(200);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL directed_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL directed_event[%0d]: got %h/%b, required %h/%b", i,
                 obs_q[i][8:1], obs_q[i][0], exp_q[i][8:1], exp_q[i][0]);
      end
    end
    obs_q.delete(); exp_q.delete();
    checks++;
    if (current_scan_code !== last_code || current_make_break !== last_mb) begin
      errors++;
      $display("FAIL directed_hold: got %h/%b, required %h/%b",
               current_scan_code, current_make_break, last_code, last_mb);
    end
  endtask

  task automatic test_timeout();
    // Partial frame: start + 3 data bits, then silence past the timeout
    send_frame(8'h00, 1'b0, 4);
    wait_clks(TMO + 500);
    send_byte(8'h1C);
    wait_clks(50);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
      errors++;
      $display("FAIL timeout_recover: got %0d events (first %h), required 1 event %h",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0, exp_q[0]);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_reset_midframe();
    send_byte(8'h12);
    send_byte(8'hF0);
    send_frame(8'h5A, 1'b0, 5);
    rst = 1'b1;
    wait_clks(2);
    @(negedge clk);
    checks++;
    if ({current_scan_code, current_make_break, key_event_valid} !== 10'h000) begin
      errors++;
      $display("FAIL midframe_reset_outputs: got code=%h mb=%b vld=%b, required 00/0/0",
               current_scan_code, current_make_break, key_event_valid);
    end
    rst = 1'b0;
    m_ext = 0; m_brk = 0; last_code = 8'h00; last_mb = 1'b0;
    obs_q.delete(); exp_q.delete();
    wait_clks(20);
    // Pending break prefix must have been dropped: expect a make
    send_byte(8'h1C);
    wait_clks(50);
    checks++;
    if (obs_q.size() != 1 || obs_q[0] !== 9'h039) begin
      errors++;
      $display("FAIL midframe_after_reset: got %0d events (first %h), required 1 event 039",
               obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 9'h0);
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_parity();
    send_byte(8'hF0);
    send_frame(8'h1C, 1'b1, 11);
`ifndef PS2_PARITY_CHECK_EN
    model_feed(8'h1C);
`endif
    send_byte(8'h1C);
    wait_clks(50);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL parity_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL parity_event[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic test_random();
    logic [7:0] b;
    for (int n = 0; n < 24; n++) begin
      case ($urandom_range(0, 3))
        0: b = 8'hE0;
        1: b = 8'hF0;
        default: begin
          b = 8'($urandom_range(0, 255));
          if (b == 8'hE0 || b == 8'hF0) b = 8'h29;
        end
      endcase
      send_byte(b);
    end
    send_byte(8'h75);
    wait_clks(50);
    checks++;
    if (obs_q.size() != exp_q.size()) begin
      errors++;
      $display("FAIL random_count: got %0d events, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i] !== exp_q[i]) begin
        errors++;
        $display("FAIL random_event[%0d]: got %h, required %h", i, obs_q[i], exp_q[i]);
      end
    end
    obs_q.delete(); exp_q.delete();
    wait_clks(300);
    checks++;
    if (current_scan_code !== last_code || current_make_break !== last_mb) begin
      errors++;
      $display("FAIL random_hold: got %h/%b, required %h/%b",
               current_scan_code, current_make_break, last_code, last_mb);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_timeout();
    test_reset_midframe();
    test_parity();
    test_random();
    checks++;
    if (consec != 0) begin
      errors++;
      $display("FAIL pulse_width: got %0d back-to-back valid cycles, required 0", consec);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ps2_keyboard.md
Name: ps2_keyboard

Overview:
- PS/2 host-side receiver and scan-code decoder for the game input path.
- Samples the asynchronous ps2_clk and ps2_data lines in the system clock domain and deframes 11-bit device-to-host frames.
- Strips E0 (extended) and F0 (break) prefixes, then reports each completed key event as a base scan code, a make/break flag and a one-cycle valid pulse.
- Consumed by the game's key-mapping logic: left/right/up arrows, space = hard drop, left shift = hold.

Parameters:
- FILTER_LEN, 8: number of consecutive system clocks the synchronized ps2_clk must hold a new level before the filtered clock changes.
- TIMEOUT_CYCLES, 200000: idle system clocks (2 ms at 100 MHz) inside a partial frame before the deframer aborts and returns to idle.

Ports:
- clk  input  1  system clock, 100 MHz nominal.
- rst  input  1  synchronous, active-high reset.
- ps2_clk  input  1  PS/2 clock from keyboard; asynchronous, idle high.
- ps2_data  input  1  PS/2 data from keyboard; asynchronous, idle high.
- current_scan_code  output  8  base scan code of the last event, prefixes stripped.
- current_make_break  output  1  1 = make (press), 0 = break (release) for the last event.
- key_event_valid  output  1  one-clock pulse when a new event is loaded.

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Reset state: current_scan_code=0x00, current_make_break=0, key_event_valid=0. Extended and break flags cleared, bit counter=0, shift register cleared, filter state=1 (idle high), timeout counter=0.
- Synchronization: ps2_clk and ps2_data each pass through a 2-FF synchronizer.
- Filtering: synchronized ps2_clk goes through the FILTER_LEN stability filter. A falling edge of the filtered clock is a sample strobe, and data is sampled from synchronized ps2_data on that strobe.
- Frame format, in order: start bit (0), data[0..7] LSB first, parity (odd over data plus parity), stop bit (1). The bit counter runs 0..10.
- Start-bit check: if the start bit samples 1, discard it and keep the counter at 0.
- Frame completion: on the stop-bit strobe the frame is complete.
- Frame acceptance: the frame is accepted only if stop=1 (and parity passes, see Optional Feature). A rejected frame is discarded silently and the counter returns to 0.
- Timeout: while the counter is nonzero, the timeout counter increments every clk and clears on each strobe. Reaching TIMEOUT_CYCLES resets the counter to 0 and drops the partial frame.
- Decoder, per accepted byte B, evaluated the cycle after frame completion:
  - B=E0: set ext flag; no event.
  - B=F0: set brk flag; no event.
  - Any other B: current_scan_code<=B, current_make_break<=~brk, key_event_valid<=1 for exactly one clk; then clear ext and brk.
- Prefix sequences: E0 F0 xx gives a break of xx; E0 xx gives a make of xx; F0 xx gives a break of xx. Repeated prefixes stay set (idempotent).
- Output hold: current_scan_code and current_make_break hold their values until the next event; they are not cleared after the pulse.
- Pulse shape: key_event_valid is never asserted on two consecutive cycles and never asserted for prefix bytes.
- Latency: the event pulse asserts within 3 clk of the filtered falling edge of the stop bit.
- Reset mid-frame: discards the partial frame and any pending prefix flags.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: a frame whose data-plus-parity has even population count is rejected. No byte reaches the decoder and the prefix flags are unchanged.
- Undefined: the parity bit is sampled but ignored, and any frame with a valid start and stop bit is accepted.

Test Plan:
- Common bench setup: 100 MHz clk; PS/2 bit period 40 us (20 us low, 20 us high); data set up before each clock fall; 50 us gap between bytes.
- Send 1C -> single pulse; scan_code=0x1C, make_break=1.
- Send F0 then 1C -> no pulse after F0; one pulse with scan_code=0x1C, make_break=0.
- Send E0 then 6B, then E0 F0 6B -> first sequence: pulse with 0x6B make=1; second sequence: pulse with 0x6B make=0; no pulses on any E0 or F0.
- Send 12, then 29, then E0 75 -> pulses with (0x12,1), (0x29,1), (0x75,1); outputs hold between events.
- Abort 4 bits into a frame, wait more than 2 ms, then send 1C -> clean event (0x1C,1). Assert rst mid-frame -> all outputs return to reset values.
- With PS2_PARITY_CHECK_EN defined, send 1C with an even parity bit -> no pulse and outputs unchanged. A subsequent good 1C -> event (0x1C,1).
